// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encodings,
// default geometry and memory request enable levels.
package inst_cache_pkg;

    typedef enum logic {
        InstCacheIdle   = 1'b0,
        InstCacheRefill = 1'b1
    } refill_state_e;

    localparam int unsigned DefNumLines  = 16;
    localparam int unsigned DefLineWords = 4;

    localparam logic MemReqEnable  = 1'b1;
    localparam logic MemReqDisable = 1'b0;

    // Saturating 32-bit increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Line refill engine: owns the REFILL FSM, word counter, discard flag and the
// req/ack memory handshake; streams each returned word to the parent's storage.
module inst_cache_refill
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DefLineWords,
    localparam int unsigned OFF = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [29-OFF:0]   line_i,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    output logic              wr_en_o,
    output logic [OFF-1:0]    wr_word_o,
    output logic [31:0]       wr_data_o,
    output logic              done_o,
    output logic              keep_o,
    output logic [29-OFF:0]   line_o
);

    localparam logic [OFF-1:0] LastWord = OFF'(LINE_WORDS - 1);

    refill_state_e      state_q, state_d;
    logic [OFF-1:0]     cnt_q, cnt_d;
    logic [29-OFF:0]    line_q, line_d;
    logic               discard_q, discard_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        discard_d  = discard_q;
        wr_en_o    = 1'b0;
        done_o     = 1'b0;
        mem_req_o  = MemReqDisable;
        mem_addr_o = 32'h0;
        unique case (state_q)
            InstCacheIdle: begin
                if (start_i) begin
                    line_d    = line_i;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    state_d   = InstCacheRefill;
                end
            end
            InstCacheRefill: begin
                mem_req_o  = MemReqEnable;
                // Line base has zero offset bits, so concatenation equals base + 4*cnt.
                mem_addr_o = {line_q, cnt_q, 2'b00};
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (mem_ack_i) begin
                    wr_en_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        done_o  = 1'b1;
                        cnt_d   = '0;
                        state_d = InstCacheIdle;
                    end
                end
            end
        endcase
    end

    assign busy_o    = (state_q == InstCacheRefill);
    assign wr_word_o = cnt_q;
    assign wr_data_o = mem_data_i;
    assign line_o    = line_q;
    // A flush on the final ack cycle must also leave the line invalid.
    assign keep_o    = done_o & ~discard_q & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= InstCacheIdle;
            cnt_q     <= '0;
            line_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with combinational hit path.
// Define INST_CACHE_STATS_EN to build saturating hit/miss counters.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DefNumLines,
    parameter int unsigned LINE_WORDS = DefLineWords
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int unsigned OFF     = $clog2(LINE_WORDS);
    localparam int unsigned IDX     = $clog2(NUM_LINES);
    localparam int unsigned TAG     = 30 - OFF - IDX;
    localparam int unsigned ENTRIES = NUM_LINES * LINE_WORDS;

    logic [OFF-1:0] word;
    logic [IDX-1:0] index;
    logic [TAG-1:0] tag;
    logic [1:0]     unused_addr;

    assign word        = addr_i[OFF+1:2];
    assign index       = addr_i[OFF+IDX+1:OFF+2];
    assign tag         = addr_i[31:OFF+IDX+2];
    assign unused_addr = addr_i[1:0];

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG-1:0]       tag_q  [NUM_LINES];
    logic [TAG-1:0]       tag_d  [NUM_LINES];
    logic [31:0]          data_q [ENTRIES];
    logic [31:0]          data_d [ENTRIES];

    logic            busy;
    logic            hit;
    logic            idle_hit;
    logic            start;
    logic            wr_en;
    logic [OFF-1:0]  wr_word;
    logic [31:0]     wr_data;
    logic            done;
    logic            keep;
    logic [29-OFF:0] fill_line;
    logic [IDX-1:0]  fill_idx;
    logic [TAG-1:0]  fill_tag;

    assign fill_idx = fill_line[IDX-1:0];
    assign fill_tag = fill_line[29-OFF:IDX];

    assign hit      = ce_i & valid_q[index] & (tag_q[index] == tag);
    assign idle_hit = ~busy & hit;
    assign start    = ~busy & ce_i & ~hit;
    assign stall_o  = busy | start;
    assign inst_o   = idle_hit ? data_q[{index, word}] : 32'h0;

    inst_cache_refill #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .flush_i    (flush_i),
        .line_i     (addr_i[31:OFF+2]),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .busy_o     (busy),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .wr_en_o    (wr_en),
        .wr_word_o  (wr_word),
        .wr_data_o  (wr_data),
        .done_o     (done),
        .keep_o     (keep),
        .line_o     (fill_line)
    );

    always_comb begin
        valid_d = valid_q;
        // The victim line is about to be overwritten word by word.
        if (start) begin
            valid_d[index] = 1'b0;
        end
        if (flush_i) begin
            valid_d = '0;
        end
        if (keep) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (wr_en) begin
            data_d[{fill_idx, wr_word}] = wr_data;
        end
        if (done) begin
            tag_d[fill_idx] = fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

`ifdef INST_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (idle_hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end
        if (start) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule
